// File: rtl/aes128_key_expand_inv.sv
// AES-128 inverse-cipher round-key source: expands the key forward once to reach rk10,
// then walks the schedule backwards one round per cycle while the core decrypts.
module aes128_key_expand_inv #(
    parameter int NR = 10
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         decipher_en,
    input  logic         rkey_en,
    input  logic [3:0]   round_num,
    output logic [127:0] round_key_10,
    output logic [127:0] round_key_inv,
    output logic         key_ready,
    output logic         key_err
);

    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [1:0] {S_EMPTY, S_EXPAND, S_READY, S_RUN} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine(a^254); a^254 is the field inverse and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] b;
        sq = a;
        b  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_work;
    logic [127:0] r_rk10;
    logic [127:0] r_rki;
    logic         r_ready;
    logic         r_err;

    logic [127:0] w_prev_src;
    logic [31:0]  w_p3;
    logic [31:0]  w_sw_in;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [7:0]   w_rc;
    logic [127:0] w_fwd;
    logic [127:0] w_prev;

    // Forward and inverse steps never run in the same cycle, so they share one SubWord.
    assign w_prev_src = (r_state == S_READY) ? r_rk10 : r_rki;
    assign w_p3       = w_prev_src[31:0] ^ w_prev_src[63:32];

    always_comb begin
        w_sw_in = w_p3;
        w_rc    = rcon(LP_NR - round_num);
        if (r_state == S_EXPAND) begin
            w_sw_in = r_work[31:0];
            w_rc    = rcon(r_cnt);
        end else if (r_state == S_READY) begin
            w_rc    = rcon(LP_NR);
        end
    end

    assign w_rot = {w_sw_in[23:0], w_sw_in[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub
            assign w_sub[8*gi +: 8] = sbox(w_rot[8*gi +: 8]);
        end
    endgenerate

    assign w_t = w_sub ^ {w_rc, 24'h0};

    assign w_fwd[127:96] = r_work[127:96] ^ w_t;
    assign w_fwd[95:64]  = r_work[95:64]  ^ w_fwd[127:96];
    assign w_fwd[63:32]  = r_work[63:32]  ^ w_fwd[95:64];
    assign w_fwd[31:0]   = r_work[31:0]   ^ w_fwd[63:32];

    assign w_prev[127:96] = w_prev_src[127:96] ^ w_t;
    assign w_prev[95:64]  = w_prev_src[95:64] ^ w_prev_src[127:96];
    assign w_prev[63:32]  = w_prev_src[63:32] ^ w_prev_src[95:64];
    assign w_prev[31:0]   = w_p3;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_cnt   <= 4'd0;
            r_work  <= '0;
            r_rk10  <= '0;
            r_rki   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_EMPTY, S_EXPAND, S_READY: begin
                    if (key_load) begin
                        r_work  <= key_in;
                        r_cnt   <= 4'd1;
                        r_state <= S_EXPAND;
                        r_ready <= 1'b0;
                        r_err   <= decipher_en;
                    end else if (r_state == S_READY) begin
                        if (decipher_en) begin
                            r_rki   <= w_prev;
                            r_state <= S_RUN;
                            r_ready <= 1'b0;
                        end
                    end else begin
                        r_err <= decipher_en;
                        if (r_state == S_EXPAND) begin
                            r_work <= w_fwd;
                            r_cnt  <= r_cnt + 4'd1;
                            if (r_cnt == LP_NR) begin
                                r_rk10  <= w_fwd;
                                r_state <= S_READY;
                                r_ready <= 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    r_err <= key_load;
                    if (rkey_en) begin
                        if (round_num == LP_NR) begin
                            r_state <= S_READY;
                            r_ready <= 1'b1;
                        end else if (round_num != 4'd0 && round_num < LP_NR) begin
                            r_rki <= w_prev;
                        end
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign round_key_10  = r_rk10;
    assign round_key_inv = r_rki;
    assign key_ready     = r_ready;
    assign key_err       = r_err;

endmodule

// File: tb/tb_aes128_key_expand_inv.sv
// Randomised bench for aes128_key_expand_inv against a full forward key-schedule model.
module tb_aes128_key_expand_inv;

    logic         clk_sys;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic         decipher_en;
    logic         rkey_en;
    logic [3:0]   round_num;
    logic [127:0] round_key_10;
    logic [127:0] round_key_inv;
    logic         key_ready;
    logic         key_err;

    aes128_key_expand_inv #(.NR(10)) dut (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_load      (key_load),
        .decipher_en   (decipher_en),
        .rkey_en       (rkey_en),
        .round_num     (round_num),
        .round_key_10  (round_key_10),
        .round_key_inv (round_key_inv),
        .key_ready     (key_ready),
        .key_err       (key_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int           n_vec = 0;
    int           n_err = 0;
    logic [7:0]   sb [256];
    logic [127:0] m_rk [11];
    logic [127:0] cap_r1;
    logic [127:0] cap_r10;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables over generator 3, then the bitwise affine map.
    task automatic build_sbox();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] e;
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        e = 8'h01;
        c = 8'h63;
        for (int i = 0; i < 255; i++) begin
            ex[i]  = e;
            lg[e]  = i;
            e      = e ^ xt(e);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8]
                     ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
            sb[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called on a falling edge. err_at: -1 none, 0 decipher_en with key_load, k>0 in expand cycle k.
    task automatic load_key(input logic [127:0] k, input int err_at);
        int cyc;
        key_in      = k;
        key_load    = 1'b1;
        decipher_en = (err_at == 0);
        @(negedge clk_sys);
        key_load    = 1'b0;
        decipher_en = 1'b0;
        model_expand(k);
        chk("err_on_load", {127'b0, key_err}, (err_at == 0) ? 128'd1 : 128'd0);
        cyc = 1;
        while (!key_ready && cyc < 30) begin
            if (cyc == err_at) decipher_en = 1'b1;
            @(negedge clk_sys);
            decipher_en = 1'b0;
            if (cyc == err_at) chk("err_expand", {127'b0, key_err}, 128'd1);
            cyc++;
        end
        chk("latency", 128'(cyc - 1), 128'd10);
        chk("rk10", round_key_10, m_rk[10]);
    endtask

    // Called on a falling edge in READY. load_at: round with an illegal key_load; stop_at: abort round.
    task automatic decrypt(input int load_at, input int stop_at);
        chk("ready_pre", {127'b0, key_ready}, 128'd1);
        decipher_en = 1'b1;
        @(negedge clk_sys);
        decipher_en = 1'b0;
        chk("ready_run", {127'b0, key_ready}, 128'd0);
        chk("rk9_start", round_key_inv, m_rk[9]);
        for (int n = 1; n <= 10; n++) begin
            round_num = 4'(n);
            rkey_en   = 1'b1;
            if (n == stop_at) return;
            if (n == load_at) begin
                key_in   = rnd128();
                key_load = 1'b1;
            end
            if (n == 1) cap_r1 = round_key_inv;
            if (n == 10) cap_r10 = round_key_inv;
            chk($sformatf("rki_r%0d", n), round_key_inv, m_rk[10-n]);
            @(negedge clk_sys);
            key_load = 1'b0;
            if (n == load_at) chk("err_run", {127'b0, key_err}, 128'd1);
        end
        rkey_en   = 1'b0;
        round_num = 4'd0;
        chk("ready_post", {127'b0, key_ready}, 128'd1);
        chk("rk0_hold", round_key_inv, m_rk[0]);
    endtask

    initial begin
        logic [127:0] k_fips;
        k_fips      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        build_sbox();
        rst_n       = 1'b0;
        key_in      = '0;
        key_load    = 1'b0;
        decipher_en = 1'b0;
        rkey_en     = 1'b0;
        round_num   = 4'd0;
        repeat (2) @(negedge clk_sys);
        chk("rst_rk10", round_key_10, 128'd0);
        chk("rst_rki", round_key_inv, 128'd0);
        chk("rst_ready", {127'b0, key_ready}, 128'd0);
        chk("rst_err", {127'b0, key_err}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        decipher_en = 1'b1;
        @(negedge clk_sys);
        decipher_en = 1'b0;
        chk("err_empty", {127'b0, key_err}, 128'd1);
        chk("ready_empty", {127'b0, key_ready}, 128'd0);

        load_key(k_fips, -1);
        chk("rk10_fips", round_key_10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        decrypt(0, 0);
        chk("rk9_fips", cap_r1, 128'hac7766f319fadc2128d12941575c006e);
        chk("rk0_fips", cap_r10, k_fips);
        decrypt(0, 0);
        chk("rk9_again", cap_r1, 128'hac7766f319fadc2128d12941575c006e);

        load_key(128'h000102030405060708090a0b0c0d0e0f, -1);
        chk("rk10_seq", round_key_10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        decrypt(4, 0);

        load_key(rnd128(), 3);
        decrypt(0, 0);

        // Reload mid-expansion: only the second key should survive.
        key_in   = rnd128();
        key_load = 1'b1;
        @(negedge clk_sys);
        key_load = 1'b0;
        repeat (4) @(negedge clk_sys);
        load_key(rnd128(), -1);
        decrypt(0, 0);

        load_key(rnd128(), 0);
        decrypt(0, 0);

        for (int it = 0; it < 6; it++) begin
            load_key(rnd128(), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : -1);
            decrypt(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0, 0);
            decrypt(0, 0);
        end

        load_key(rnd128(), -1);
        decrypt(0, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rk10", round_key_10, 128'd0);
        chk("midrst_rki", round_key_inv, 128'd0);
        chk("midrst_ready", {127'b0, key_ready}, 128'd0);
        chk("midrst_err", {127'b0, key_err}, 128'd0);
        @(negedge clk_sys);
        rkey_en   = 1'b0;
        round_num = 4'd0;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("midrst_idle", {127'b0, key_ready}, 128'd0);
        decipher_en = 1'b1;
        @(negedge clk_sys);
        decipher_en = 1'b0;
        chk("midrst_err_empty", {127'b0, key_err}, 128'd1);
        load_key(rnd128(), -1);
        decrypt(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
